// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state codes,
// opcode constants, mux-select codes and the decoded control bundle.
package multicycle_controller_pkg;

    localparam int unsigned AWL  = 6;
    localparam int unsigned SW_W = 4;

    typedef enum logic [SW_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [AWL-1:0] OP_RTYPE = 6'b000000;
    localparam logic [AWL-1:0] OP_LW    = 6'b100011;
    localparam logic [AWL-1:0] OP_SW    = 6'b101011;
    localparam logic [AWL-1:0] OP_ADDI  = 6'b001000;
    localparam logic [AWL-1:0] OP_BEQ   = 6'b000100;
    localparam logic [AWL-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control bundle produced by the state decoder
    typedef struct packed {
        logic       iord;
        logic       irwe;
        logic       dmwe;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       rfdsel;
        logic       mtorfsel;
        logic       rfwe;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: current state (plus MemReady/Zero qualifiers) to
// datapath controls. Optional macro MC_ILLEGAL_TRAP_EN enables Halted in HALT.
module mc_ctrl_decode
    import multicycle_controller_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl_c
);

    // Every control defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.iord    = 1'b0;
                ctrl_c.alusrca = 1'b0;
                ctrl_c.alusrcb = SRCB_FOUR;
                ctrl_c.aluop   = ALUOP_ADD;
                ctrl_c.pcsrc   = PCSRC_ALU;
                ctrl_c.irwe    = mem_ready;
                ctrl_c.pcen    = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alusrca = 1'b0;
                ctrl_c.alusrcb = SRCB_IMMSH;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_c.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.rfdsel   = 1'b0;
                ctrl_c.mtorfsel = 1'b1;
                ctrl_c.rfwe     = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.iord = 1'b1;
                ctrl_c.dmwe = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_REGB;
                ctrl_c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c.rfdsel   = 1'b1;
                ctrl_c.mtorfsel = 1'b0;
                ctrl_c.rfwe     = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_REGB;
                ctrl_c.aluop   = ALUOP_SUB;
                ctrl_c.pcsrc   = PCSRC_ALUOUT;
                ctrl_c.pcen    = zero;
            end
            S_ADDIEX: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_c.rfdsel   = 1'b0;
                ctrl_c.mtorfsel = 1'b0;
                ctrl_c.rfwe     = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pcsrc = PCSRC_JUMP;
                ctrl_c.pcen  = 1'b1;
            end
            S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                ctrl_c.halted = 1'b1;
`else
                ctrl_c.halted = 1'b0;
`endif
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs
// come from mc_ctrl_decode. Optional macro MC_ILLEGAL_TRAP_EN traps unknown
// opcodes into HALT instead of treating them as NOPs.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [AWL-1:0]  Opcode,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            IorD,
    output logic            IRWE,
    output logic            DMWE,
    output logic            PCEn,
    output logic [1:0]      PCSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic            RFDSel,
    output logic            MtoRFSel,
    output logic            RFWE,
    output logic [SW_W-1:0] State,
    output logic            Halted
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_c;

    // State register with synchronous reset to FETCH
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Opcode is consulted only in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (MemReady),
        .zero      (Zero),
        .ctrl_c    (ctrl_c)
    );

    assign IorD     = ctrl_c.iord;
    assign IRWE     = ctrl_c.irwe;
    assign DMWE     = ctrl_c.dmwe;
    assign PCEn     = ctrl_c.pcen;
    assign PCSrc    = ctrl_c.pcsrc;
    assign ALUSrcA  = ctrl_c.alusrca;
    assign ALUSrcB  = ctrl_c.alusrcb;
    assign ALUOp    = ctrl_c.aluop;
    assign RFDSel   = ctrl_c.rfdsel;
    assign MtoRFSel = ctrl_c.mtorfsel;
    assign RFWE     = ctrl_c.rfwe;
    assign Halted   = ctrl_c.halted;
    assign State    = SW_W'(state_q);

endmodule
